div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle iterative divider in the Execute stage of the five-stage pipeline.
- Executes DIV/DIVU and produces the HI (remainder) and LO (quotient) results.
- Drives divstall, which the hazard unit consumes to stall F/D/E and flush M while a division is in flight.
- Radix-2 restoring algorithm: one quotient bit per cycle.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CNT_W, 6: iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- div_en  in  1  a valid DIV/DIVU occupies E this cycle.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU.
- srca  in  WIDTH  dividend (forwarded rs value).
- srcb  in  WIDTH  divisor (forwarded rt value).
- annul  in  1  cancel the in-flight division (exception/flush); highest priority after rst.
- divstall  out  1  E must hold; combinational.
- div_valid  out  1  one-cycle pulse; hi_o/lo_o are valid.
- hi_o  out  WIDTH  remainder.
- lo_o  out  WIDTH  quotient.

Behaviour:
- Reset: state=IDLE, counter=0, all internal registers 0; hi_o=0, lo_o=0, div_valid=0. divstall=0 except when div_en=1 in IDLE.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On div_en=1 (cycle T): latch |srca|, |srcb|, the sign of srca, sign(srca)^sign(srcb) and div_signed; clear remainder and counter; go to BUSY.
  - |x| applies only when div_signed=1; unsigned operands pass through unchanged.
- BUSY (T+1..T+WIDTH):
  - Each cycle: shift {rem,quo} left 1; trial = rem − divisor (WIDTH+1 bits).
  - If trial is non-negative: rem=trial and quo LSB=1; otherwise quo LSB=0.
  - counter++. After WIDTH iterations, go to DONE.
- DONE (T+WIDTH+1): apply sign fixup, register the results, div_valid=1, go to IDLE.
  - Quotient is negated if the latched sign XOR is 1.
  - Remainder is negated if the latched dividend sign is 1.
- divstall = div_en & (state != DONE). It is high for WIDTH+1 cycles (33 at default) and low in DONE, so E advances exactly once with the result.
- hi_o/lo_o hold their last values until the next DONE.
- Divide by zero (srcb==0): completes normally with lo_o = all ones and hi_o = srca (raw, unsigned interpretation). No trap.
- Overflow: signed 0x80000000 / −1 gives lo_o=0x80000000, hi_o=0, falling out naturally from WIDTH-bit wrap.
- annul=1 in any state: next state IDLE, div_valid=0, no result update, divstall=0 that cycle.
- rst mid-operation: same as annul, plus the reset values above.
- div_en dropping while in BUSY (E flushed by a higher-level event): abort to IDLE; treated as annul.
- Back-to-back divides: the DONE→IDLE cycle leaves E; the next divide starts when it reaches E. There is no pipelining of operands.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- With the macro defined: in IDLE, if srcb==0 or |srcb| > |srca|, skip BUSY and go straight to DONE. Quotient is 0 (all ones if divide by zero); remainder is the dividend. divstall is high for exactly 1 cycle.
- Without the macro: every division takes WIDTH+1 stall cycles, including divide by zero.

Decomposition:
- Shared package (pipeline package): WIDTH default; div state enum {IDLE, BUSY, DONE}; DIV/DIVU funct constants, shared with the controller.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: {rem,quo}, divisor. Outputs: next {rem,quo}.
  - Keeps the FSM file small and allows later unrolling to 2 bits/cycle.

Test Plan:
- DIVU 100/7: div_en held at T → divstall high T..T+32, low at T+33; div_valid at T+33 with lo_o=14, hi_o=2.
- DIV −7/2 (0xFFFFFFF9, 0x2) → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 7/−2 → lo_o=0xFFFFFFFD, hi_o=1.
- DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0. DIVU 5/0 → lo_o=0xFFFFFFFF, hi_o=5 after 33 stall cycles (1 stall cycle with DIV_EARLY_OUT_EN).
- annul pulse at T+10 → state IDLE at T+11, no div_valid, hi_o/lo_o unchanged. Repeat the scenario with rst at T+10 → all outputs 0.
- Two consecutive DIVU (20/3, then 9/4) → two div_valid pulses 34 cycles apart: (lo=6, hi=2), then (lo=2, hi=1). Verify no double-issue of the first divide.
- With DIV_EARLY_OUT_EN: DIVU 3/10 → divstall 1 cycle, lo_o=0, hi_o=3.

Source files
------------

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared divider width, FSM encodings and DIV/DIVU funct codes
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef logic [1:0] divState_t;
  localparam divState_t DIV_IDLE = 2'd0;
  localparam divState_t DIV_BUSY = 2'd1;
  localparam divState_t DIV_DONE = 2'd2;

  // Shared with the controller's R-type decode
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one combinational radix-2 restoring iteration on {rem,quo}
module div_unit_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH-1:0] remQuo,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] nextRemQuo
);

  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quoShift;

  assign remShift = remQuo[2*WIDTH-1:WIDTH-1];
  assign quoShift = {remQuo[WIDTH-2:0], 1'b0};
  // remShift < 2*divisor, so the sign of the WIDTH+1 bit difference is exact
  assign trial    = remShift - {1'b0, divisor};

  always_comb begin
    nextRemQuo = {remShift[WIDTH-1:0], quoShift};
    if (!trial[WIDTH]) begin
      nextRemQuo = {trial[WIDTH-1:0], quoShift[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative DIV/DIVU unit for the E stage; DIV_EARLY_OUT_EN skips the loop for trivial quotients
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             annul,
  output logic             divstall,
  output logic             div_valid,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  divState_t          state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] remQuo;
  logic [2*WIDTH-1:0] stepOut;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rawA;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               negQuo;
  logic               negRem;
  logic               divZero;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;
  logic               doneOk;

  assign absA = (div_signed && srca[WIDTH-1]) ? -srca : srca;
  assign absB = (div_signed && srcb[WIDTH-1]) ? -srcb : srcb;

  div_unit_step #(.WIDTH(WIDTH)) stepInst (
    .remQuo     (remQuo),
    .divisor    (divisor),
    .nextRemQuo (stepOut)
  );

  // Divide by zero reports the raw dividend and an all-ones quotient regardless of sign
  always_comb begin
    resHi = negRem ? -remQuo[2*WIDTH-1:WIDTH] : remQuo[2*WIDTH-1:WIDTH];
    resLo = negQuo ? -remQuo[WIDTH-1:0] : remQuo[WIDTH-1:0];
    if (divZero) begin
      resHi = rawA;
      resLo = '1;
    end
  end

  // Results are presented in DONE itself so E can advance with them in that cycle
  assign doneOk    = (state == DIV_DONE) && !annul && !rst;
  assign div_valid = doneOk;
  assign hi_o      = doneOk ? resHi : hiReg;
  assign lo_o      = doneOk ? resLo : loReg;
  assign divstall  = div_en && (state != DIV_DONE) && !annul;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIV_IDLE;
      count   <= '0;
      remQuo  <= '0;
      divisor <= '0;
      rawA    <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      negQuo  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
    end else if (annul) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (div_en) begin
            divisor <= absB;
            rawA    <= srca;
            negRem  <= div_signed && srca[WIDTH-1];
            negQuo  <= div_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            divZero <= (srcb == '0);
            count   <= '0;
`ifdef DIV_EARLY_OUT_EN
            if ((srcb == '0) || (absB > absA)) begin
              remQuo <= {absA, {WIDTH{1'b0}}};
              state  <= DIV_DONE;
            end else begin
              remQuo <= {{WIDTH{1'b0}}, absA};
              state  <= DIV_BUSY;
            end
`else
            remQuo <= {{WIDTH{1'b0}}, absA};
            state  <= DIV_BUSY;
`endif
          end
        end
        DIV_BUSY: begin
          if (!div_en) begin
            state <= DIV_IDLE;
          end else begin
            remQuo <= stepOut;
            count  <= count + 1'b1;
            if (count == CNT_W'(WIDTH - 1)) begin
              state <= DIV_DONE;
            end
          end
        end
        DIV_DONE: begin
          hiReg <= resHi;
          loReg <= resLo;
          state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule
